muldiv_unit: RTL

- Iterative multiply/divide unit with HI/LO registers for the multi-cycle CPU's execute stage.
- Consumes the two source operands read from the register file (rs on port A, rt on port B).
- Serves MULT/MULTU/DIV/DIVU/MTHI/MTLO; results are read back through hi/lo.
- The control FSM holds the instruction in its execute state while busy is high.

---
 rtl/muldiv_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Multiply is a shift-add over a 2*WIDTH accumulator. Divide is a restoring
// shift-subtract. Both work on magnitudes, and the recorded signs are applied
// in a single FIX cycle, so hi/lo only ever see finished results.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_lo;     // product sign (mul) or quotient sign (div)
    logic               neg_hi;     // remainder sign (div only)
    logic               div_zero;
    logic [WIDTH-1:0]   opnd;       // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0]   a_raw;      // dividend as presented, returned on divide by zero
    logic [2*WIDTH-1:0] acc;

    // Request decode; op[2]==0 selects the four multi-cycle arithmetic ops
    logic             accept_arith, accept_mt;
    logic             signed_op, sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;

    // Request decode and operand magnitudes (bit 0 of op marks the unsigned variants)
    always_comb begin
        accept_arith = start && (state == IDLE) && !op[2];
        accept_mt    = start && (state == IDLE) && (op == OP_MTHI || op == OP_MTLO);
        signed_op    = !op[0];
        sign_a       = signed_op && rs_data[WIDTH-1];
        sign_b       = signed_op && rt_data[WIDTH-1];
        mag_a        = sign_a ? -rs_data : rs_data;
        mag_b        = sign_b ? -rt_data : rt_data;
    end

    // One iteration step: shift-add for multiply, restoring shift-subtract for divide
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_diff;
    logic               rem_ge;
    logic [2*WIDTH-1:0] acc_nxt;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_ge   = (rem_sh >= {1'b0, opnd});
        // When rem_sh >= divisor, the difference is below the divisor and fits in WIDTH bits
        rem_diff = rem_sh[WIDTH-1:0] - opnd;
        if (is_div) begin
            acc_nxt = rem_ge ? {rem_diff, acc[WIDTH-2:0], 1'b1}
                             : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Sign correction and the special cases, applied when hi/lo are written in FIX
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi, res_lo;

    always_comb begin
        prod = neg_lo ? -acc : acc;
        if (is_div && div_zero) begin
            res_lo = '1;
            res_hi = a_raw;
        end else if (is_div) begin
            res_lo = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            res_hi = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end else begin
            res_lo = prod[WIDTH-1:0];
            res_hi = prod[2*WIDTH-1:WIDTH];
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: IDLE -> CALC for WIDTH iterations -> FIX -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_arith) state_nxt = CALC;
            CALC:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, and result/done registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= '0;
            a_raw    <= '0;
            acc      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_arith) begin
                        is_div   <= op[1];
                        neg_lo   <= sign_a ^ sign_b;
                        neg_hi   <= sign_a;
                        div_zero <= (rt_data == '0);
                        a_raw    <= rs_data;
                        opnd     <= op[1] ? mag_b : mag_a;
                        acc      <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                        cnt      <= '0;
                    end else if (accept_mt) begin
                        if (op == OP_MTHI) hi <= rs_data;
                        else               lo <= rs_data;
                        done <= 1'b1;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
